// File: rtl/sync_fiford_outbuf.sv
`timescale 1ns/1ps
// Two-entry first-word-fall-through read buffer behind the FIFO RAM; credit-based read requests.
// Latency: ren_i to dvalid_o is 2 rclk; full throughput; rfifo_o drops when buffer plus in-flight reaches 2.
module sync_fiford_outbuf #(
  parameter int DW = 32
) (
  input  logic          rclk,
  input  logic          rst_n,
  input  logic          ren_i,
  input  logic [DW-1:0] rdata_i,
  output logic          rfifo_o,
  input  logic          flush_i,
  output logic [DW-1:0] dout_o,
  output logic          dvalid_o,
  input  logic          dready_i,
  output logic [1:0]    occ_o,
  output logic          ovf_o
);

  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic [1:0]    occ;
  logic          inflight;
  logic          ovf;
  logic          pop;
  logic          push;
  logic [2:0]    credit;

  assign dout_o   = head;
  assign dvalid_o = (occ != 2'd0);
  assign occ_o    = occ;
  assign ovf_o    = ovf;

  assign pop  = dvalid_o & dready_i;
  assign push = inflight & ~flush_i;

  // Words already committed (buffered or in flight) minus the one leaving this cycle.
  assign credit  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign rfifo_o = ~flush_i & (credit < 3'd2);

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      inflight <= ren_i & ~flush_i;
      if (flush_i) begin
        occ <= 2'd0;
      end else begin
        unique case (occ)
          2'd0: begin
            if (push) begin
              head <= rdata_i;
              occ  <= 2'd1;
            end
          end
          2'd1: begin
            if (push && !pop) begin
              tail <= rdata_i;
              occ  <= 2'd2;
            end else if (push && pop) begin
              head <= rdata_i;
            end else if (pop) begin
              occ <= 2'd0;
            end
          end
          2'd2: begin
            // A word arriving while full is dropped; a consumer pop still advances.
            if (push) ovf <= 1'b1;
            if (pop) begin
              head <= tail;
              occ  <= 2'd1;
            end
          end
          default: occ <= 2'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sync_fiford_outbuf.sv
`timescale 1ns/1ps
// Scoreboard bench for sync_fiford_outbuf: a queue of accepted words is the reference,
// a negedge monitor pops and compares on every consumer handshake.
module tb_sync_fiford_outbuf;
  localparam int DW = 32;

  logic          rclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ren_i = 1'b0;
  logic [DW-1:0] rdata_i = '0;
  logic          rfifo_o;
  logic          flush_i = 1'b0;
  logic [DW-1:0] dout_o;
  logic          dvalid_o;
  logic          dready_i = 1'b0;
  logic [1:0]    occ_o;
  logic          ovf_o;

  sync_fiford_outbuf #(.DW(DW)) dut (
    .rclk(rclk), .rst_n(rst_n), .ren_i(ren_i), .rdata_i(rdata_i), .rfifo_o(rfifo_o),
    .flush_i(flush_i), .dout_o(dout_o), .dvalid_o(dvalid_o), .dready_i(dready_i),
    .occ_o(occ_o), .ovf_o(ovf_o)
  );

  always #5 rclk = ~rclk;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  bit            pend = 1'b0;
  logic [DW-1:0] pend_word = '0;
  int            pop_cnt = 0;
  int            max_occ = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every accepted output word must be the oldest outstanding accepted read.
  always @(negedge rclk) begin
    if (rst_n) begin
      if (int'(occ_o) > max_occ) max_occ = int'(occ_o);
      if (dvalid_o && dready_i) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_unexpected: got %h, required no word", dout_o);
        end else begin
          check("dout_order", dout_o, exp_q.pop_front());
        end
      end
      if (flush_i) exp_q.delete();
    end
  end

  // One rclk of stimulus: RAM returns the previous cycle's read, then a read is issued if
  // allowed (or forced). Only reads granted by rfifo_o enter the scoreboard.
  task automatic step(input bit want, input bit fl, input bit rdy, input bit frc,
                      input logic [DW-1:0] w);
    @(posedge rclk);
    #1;
    rdata_i  = pend ? pend_word : DW'($urandom);
    pend     = 1'b0;
    flush_i  = fl;
    dready_i = rdy;
    ren_i    = 1'b0;
    #1;
    if (frc || (want && rfifo_o)) begin
      ren_i     = 1'b1;
      pend      = 1'b1;
      pend_word = w;
      if (rfifo_o) exp_q.push_back(w);
    end
  endtask

  initial begin
    #2;
    check("rst_dout", dout_o, '0);
    check("rst_dvalid", dvalid_o, 1'b0);
    check("rst_occ", occ_o, 2'd0);
    check("rst_ovf", ovf_o, 1'b0);
    @(negedge rclk);
    rst_n = 1'b1;
    #1;
    check("rst_rfifo", rfifo_o, 1'b1);

    // Single word: visible two cycles after the read, gone one cycle after acceptance.
    step(1, 0, 0, 0, 32'hA5A5_0001);
    step(0, 0, 0, 0, '0);
    step(0, 0, 1, 0, '0);
    check("single_dvalid", dvalid_o, 1'b1);
    check("single_dout", dout_o, 32'hA5A5_0001);
    step(0, 0, 0, 0, '0);
    check("single_empty", dvalid_o, 1'b0);

    // Streaming 0..15 with consumer always ready.
    pop_cnt = 0;
    max_occ = 0;
    for (int i = 0; i < 19; i++) step(i < 16, 0, 1, 0, DW'(i));
    check("stream_count", DW'(pop_cnt), DW'(16));
    check("stream_occ_le1", max_occ > 1, 1'b0);

    // Backpressure: 10 stalled cycles mid-stream, then drain.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, DW'(100 + i));
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, DW'(200 + i));
    check("bp_occ", occ_o, 2'd2);
    check("bp_rfifo", rfifo_o, 1'b0);
    check("bp_ovf", ovf_o, 1'b0);
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0, DW'(300 + i));
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, '0);
    check("bp_drained", DW'(exp_q.size()), DW'(0));

    // Flush with one word buffered and one in flight.
    step(1, 0, 0, 0, 32'h0000_F001);
    step(1, 0, 0, 0, 32'h0000_F002);
    step(0, 1, 0, 0, '0);
    check("flush_rfifo", rfifo_o, 1'b0);
    step(0, 0, 0, 0, '0);
    check("flush_occ", occ_o, 2'd0);
    check("flush_dvalid", dvalid_o, 1'b0);
    pop_cnt = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, '0);
    check("flush_no_words", DW'(pop_cnt), DW'(0));

    // Overflow: force a read at occ=2.
    step(1, 0, 0, 0, 32'h0000_0B01);
    step(1, 0, 0, 0, 32'h0000_0B02);
    step(1, 0, 0, 0, 32'h0000_0B03);
    step(1, 0, 0, 0, 32'h0000_0B04);
    check("ovf_pre_occ", occ_o, 2'd2);
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, '0);
    check("ovf_not_yet", ovf_o, 1'b0);
    step(0, 0, 0, 0, '0);
    check("ovf_set", ovf_o, 1'b1);
    check("ovf_occ_hold", occ_o, 2'd2);
    check("ovf_head_hold", dout_o, 32'h0000_0B01);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, '0);
    check("ovf_sticky", ovf_o, 1'b1);
    check("ovf_drained", DW'(exp_q.size()), DW'(0));
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    check("ovf_survives_flush", ovf_o, 1'b1);

    // Asynchronous reset with the buffer full.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, DW'(32'h0000_0C00 + i));
    check("rstmid_pre_occ", occ_o, 2'd2);
    @(posedge rclk);
    #3;
    rst_n = 1'b0;
    ren_i = 1'b0;
    #1;
    check("rstmid_dvalid", dvalid_o, 1'b0);
    check("rstmid_occ", occ_o, 2'd0);
    check("rstmid_ovf", ovf_o, 1'b0);
    exp_q.delete();
    pend = 1'b0;
    @(negedge rclk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, '0);
    check("rstmid_rfifo", rfifo_o, 1'b1);
    check("rstmid_still_empty", occ_o, 2'd0);

    // Randomized traffic with random stalls and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      bit fl;
      fl = ($urandom_range(0, 39) == 0);
      step(!fl && ($urandom_range(0, 3) != 0), fl, $urandom_range(0, 3) != 0, 0, DW'($urandom));
    end
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, '0);
    check("rand_drained", DW'(exp_q.size()), DW'(0));
    check("rand_no_ovf", ovf_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
